// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, cache-miss stall and deferred branch flush.
// Define ID_EX_PERF_CNT_EN to add the bubble_cnt / stall_cnt performance counter outputs.
module id_ex_pipe_reg #(
    parameter int data_size = 32,
    parameter int pc_size   = 18,
    parameter int ctrl_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 ID_valid,
    input  logic [pc_size-1:0]   ID_pc,
    input  logic [ctrl_size-1:0] ID_ctrl,
    input  logic [data_size-1:0] ID_Rs_data,
    input  logic [data_size-1:0] ID_Rt_data,
    input  logic [data_size-1:0] ID_imm,
    input  logic [4:0]           ID_Rs,
    input  logic [4:0]           ID_Rt,
    input  logic [4:0]           ID_Rd,
    output logic                 EX_valid,
    output logic [pc_size-1:0]   EX_pc,
    output logic [ctrl_size-1:0] EX_ctrl,
    output logic [data_size-1:0] EX_Rs_data,
    output logic [data_size-1:0] EX_Rt_data,
    output logic [data_size-1:0] EX_imm,
    output logic [4:0]           EX_Rs,
    output logic [4:0]           EX_Rt,
    output logic [4:0]           EX_Rd,
    output logic                 load_use,
    output logic                 ID_hold
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]          bubble_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    typedef struct packed {
        logic                 valid;
        logic [pc_size-1:0]   pc;
        logic [ctrl_size-1:0] ctrl;
        logic [data_size-1:0] rs_data;
        logic [data_size-1:0] rt_data;
        logic [data_size-1:0] imm;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic [4:0]           rd;
    } ex_t;

    ex_t  ex_d, ex_q, id_cap;
    logic pending_flush_d, pending_flush_q;
    logic lu_bubble;

    // A bubble is all-zero, so Rd=0 can never match in the forwarding unit.
    assign load_use = ex_q.valid & ex_q.ctrl[1] & (ex_q.rd != 5'd0) &
                      ((ex_q.rd == ID_Rs) | (ex_q.rd == ID_Rt)) & ID_valid;
    assign ID_hold  = load_use & ~stall;

    always_comb begin
        id_cap         = '0;
        id_cap.valid   = ID_valid;
        id_cap.pc      = ID_pc;
        id_cap.ctrl    = ID_valid ? ID_ctrl : '0;
        id_cap.rs_data = ID_Rs_data;
        id_cap.rt_data = ID_Rt_data;
        id_cap.imm     = ID_imm;
        id_cap.rs      = ID_Rs;
        id_cap.rt      = ID_Rt;
        id_cap.rd      = ID_Rd;
    end

    always_comb begin
        ex_d            = ex_q;
        pending_flush_d = pending_flush_q;
        lu_bubble       = 1'b0;
        if (stall) begin
            // A flush arriving while frozen is remembered until the stall lifts.
            if (flush) pending_flush_d = 1'b1;
        end else if (flush || pending_flush_q) begin
            ex_d            = '0;
            pending_flush_d = 1'b0;
        end else if (load_use) begin
            ex_d      = '0;
            lu_bubble = 1'b1;
        end else begin
            ex_d = id_cap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q            <= '0;
            pending_flush_q <= 1'b0;
        end else begin
            ex_q            <= ex_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    assign EX_valid   = ex_q.valid;
    assign EX_pc      = ex_q.pc;
    assign EX_ctrl    = ex_q.ctrl;
    assign EX_Rs_data = ex_q.rs_data;
    assign EX_Rt_data = ex_q.rt_data;
    assign EX_imm     = ex_q.imm;
    assign EX_Rs      = ex_q.rs;
    assign EX_Rt      = ex_q.rt;
    assign EX_Rd      = ex_q.rd;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q + (lu_bubble ? 32'd1 : 32'd0);
        stall_cnt_d  = stall_cnt_q + (stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed vectors push expectations, a monitor checks each edge.
module tb_id_ex_pipe_reg;
    localparam int DW  = 32;
    localparam int PW  = 18;
    localparam int CW  = 8;
    localparam int EXW = 1 + PW + CW + 3 * DW + 15;

    localparam int CAP  = 0;
    localparam int BUB  = 1;
    localparam int HOLD = 2;
    localparam int ZERO = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush;
    logic          ID_valid;
    logic [PW-1:0] ID_pc;
    logic [CW-1:0] ID_ctrl;
    logic [DW-1:0] ID_Rs_data, ID_Rt_data, ID_imm;
    logic [4:0]    ID_Rs, ID_Rt, ID_Rd;
    logic          EX_valid;
    logic [PW-1:0] EX_pc;
    logic [CW-1:0] EX_ctrl;
    logic [DW-1:0] EX_Rs_data, EX_Rt_data, EX_imm;
    logic [4:0]    EX_Rs, EX_Rt, EX_Rd;
    logic          load_use, ID_hold;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   bubble_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.data_size(DW), .pc_size(PW), .ctrl_size(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_ctrl(ID_ctrl),
        .ID_Rs_data(ID_Rs_data), .ID_Rt_data(ID_Rt_data), .ID_imm(ID_imm),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_ctrl(EX_ctrl),
        .EX_Rs_data(EX_Rs_data), .EX_Rt_data(EX_Rt_data), .EX_imm(EX_imm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .load_use(load_use), .ID_hold(ID_hold)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        string          tag;
        logic           lu;
        logic           hold;
        logic [EXW-1:0] ex;
    } exp_t;

    exp_t           sb[$];
    int             n_vec = 0;
    int             n_bad = 0;
    logic [EXW-1:0] cur = '0;

    function automatic logic [EXW-1:0] dut_ex();
        return {EX_valid, EX_pc, EX_ctrl, EX_Rs_data, EX_Rt_data, EX_imm, EX_Rs, EX_Rt, EX_Rd};
    endfunction

    task automatic check(input string tag, input logic [EXW+1:0] got, input logic [EXW+1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: {load_use,ID_hold,EX} got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [PW-1:0] pc, input logic [CW-1:0] ctrl,
                          input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ID_valid = v;  ID_pc = pc;  ID_ctrl = ctrl;
        ID_Rs_data = rsd;  ID_Rt_data = rtd;  ID_imm = imm;
        ID_Rs = rs;  ID_Rt = rt;  ID_Rd = rd;
    endtask

    // Push the EX state expected after the coming edge plus the hazard flags expected before it.
    task automatic step(input string tag, input int act, input logic elu, input logic ehold);
        exp_t e;
        case (act)
            CAP:      cur = {ID_valid, ID_pc, (ID_valid ? ID_ctrl : {CW{1'b0}}),
                             ID_Rs_data, ID_Rt_data, ID_imm, ID_Rs, ID_Rt, ID_Rd};
            BUB, ZERO: cur = '0;
            default:  ;
        endcase
        e.tag  = tag;
        e.lu   = elu;
        e.hold = ehold;
        e.ex   = cur;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        logic lu_s, hold_s;
        forever begin
            @(posedge clk);
            lu_s   = load_use;
            hold_s = ID_hold;
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, {lu_s, hold_s, dut_ex()}, {e.lu, e.hold, e.ex});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d expectations pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b0;  stall = 1'b0;  flush = 1'b0;
        set_id(1'b0, '0, '0, '0, '0, '0, 5'd0, 5'd0, 5'd0);
        #1;
        check("reset_state", {load_use, ID_hold, dut_ex()}, '0);
        @(negedge clk);
        rst = 1'b1;

        // basic capture, then a load followed by a dependent instruction
        set_id(1'b1, 18'h100, 8'h01, 32'h0000_1234, 32'h0000_0055, 32'h4, 5'd5, 5'd6, 5'd7);
        step("capture_basic", CAP, 1'b0, 1'b0);
        set_id(1'b1, 18'h104, 8'h03, 32'hAAAA_0001, 32'hBBBB_0002, 32'h8, 5'd1, 5'd2, 5'd8);
        step("capture_load", CAP, 1'b0, 1'b0);
        set_id(1'b1, 18'h108, 8'h01, 32'h0000_0003, 32'h0000_0004, 32'hC, 5'd3, 5'd8, 5'd9);
        step("load_use_bubble", BUB, 1'b1, 1'b1);
        step("load_use_replay", CAP, 1'b0, 1'b0);

        // load writing r0 never creates a hazard
        set_id(1'b1, 18'h10C, 8'h02, 32'h1111_1111, 32'h2222_2222, 32'h10, 5'd4, 5'd4, 5'd0);
        step("capture_load_r0", CAP, 1'b0, 1'b0);
        set_id(1'b1, 18'h110, 8'h01, 32'h3333_3333, 32'h4444_4444, 32'h14, 5'd0, 5'd0, 5'd10);
        step("no_hazard_r0", CAP, 1'b0, 1'b0);

        // three stall cycles with changing ID, flush seen in the second one
        stall = 1'b1;
        set_id(1'b1, 18'h114, 8'h01, 32'h5, 32'h6, 32'h18, 5'd10, 5'd11, 5'd12);
        step("stall_c1", HOLD, 1'b0, 1'b0);
        flush = 1'b1;
        set_id(1'b1, 18'h118, 8'h03, 32'h7, 32'h8, 32'h1C, 5'd13, 5'd14, 5'd15);
        step("stall_c2_flush", HOLD, 1'b0, 1'b0);
        flush = 1'b0;
        set_id(1'b0, 18'h11C, 8'h05, 32'h9, 32'hA, 32'h20, 5'd16, 5'd17, 5'd18);
        step("stall_c3", HOLD, 1'b0, 1'b0);
        stall = 1'b0;
        set_id(1'b1, 18'h120, 8'h01, 32'hB, 32'hC, 32'h24, 5'd19, 5'd20, 5'd21);
        step("pending_flush_bubble", BUB, 1'b0, 1'b0);

        // stall together with load_use: no hold, no bubble until the stall lifts
        set_id(1'b1, 18'h200, 8'h03, 32'hD, 32'hE, 32'h28, 5'd1, 5'd2, 5'd12);
        step("capture_load2", CAP, 1'b0, 1'b0);
        stall = 1'b1;
        set_id(1'b1, 18'h204, 8'h01, 32'hF, 32'h10, 32'h2C, 5'd12, 5'd3, 5'd13);
        step("stall_with_load_use", HOLD, 1'b1, 1'b0);
        stall = 1'b0;
        step("load_use_after_stall", BUB, 1'b1, 1'b1);
        step("replay_after_stall", CAP, 1'b0, 1'b0);

        // flush and load_use together: a single bubble
        set_id(1'b1, 18'h300, 8'h03, 32'h11, 32'h12, 32'h30, 5'd1, 5'd2, 5'd14);
        step("capture_load3", CAP, 1'b0, 1'b0);
        flush = 1'b1;
        set_id(1'b1, 18'h304, 8'h01, 32'h13, 32'h14, 32'h34, 5'd14, 5'd0, 5'd15);
        step("flush_and_load_use", BUB, 1'b1, 1'b1);
        flush = 1'b0;
        step("replay_after_flush", CAP, 1'b0, 1'b0);

        // invalid ID instruction clears control but keeps the other fields
        set_id(1'b0, 18'h400, 8'hFF, 32'h15, 32'h16, 32'h38, 5'd1, 5'd2, 5'd3);
        step("capture_invalid", CAP, 1'b0, 1'b0);

`ifdef ID_EX_PERF_CNT_EN
        check32("bubble_cnt", bubble_cnt, 32'd2);
        check32("stall_cnt", stall_cnt, 32'd4);
`endif

        // async reset while EX is valid and a flush is pending
        set_id(1'b1, 18'h500, 8'h01, 32'h17, 32'h18, 32'h3C, 5'd4, 5'd5, 5'd16);
        step("capture_pre_reset", CAP, 1'b0, 1'b0);
        stall = 1'b1;
        flush = 1'b1;
        step("stall_flush_pre_reset", HOLD, 1'b0, 1'b0);
        stall = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 18'h504, 8'h01, 32'h19, 32'h1A, 32'h40, 5'd6, 5'd7, 5'd17);
        #2;
        rst = 1'b0;
        #1;
        check("reset_async_immediate", {load_use, ID_hold, dut_ex()}, '0);
        step("reset_held_edge", ZERO, 1'b0, 1'b0);
        rst = 1'b1;
        step("capture_after_reset", CAP, 1'b0, 1'b0);

        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register for the 5-stage pipelined CPU with L1 caches. It captures decoded operands and control from ID and presents them to EX, including EX_Rs_data and EX_Rt_data, which feed the EX operand forwarding muxes. It also performs load-use hazard detection, with bubble insertion and an ID-hold request. It honours a global cache-miss stall and a branch/jump flush, with a pending-flush latch.

Parameters:
data_size, 32, width of operand data and immediate
pc_size, 18, width of PC
ctrl_size, 8, width of packed control bundle; bit0=RegWrite, bit1=MemRead, bit2=MemWrite, others opaque

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
stall  input  1  global freeze from L1 I/D cache miss
flush  input  1  branch taken / jump in EX: kill instruction entering EX
ID_valid  input  1  ID holds a real instruction
ID_pc  input  pc_size  PC of ID instruction
ID_ctrl  input  ctrl_size  decoded control bundle
ID_Rs_data  input  data_size  register file read port A
ID_Rt_data  input  data_size  register file read port B
ID_imm  input  data_size  sign-extended immediate
ID_Rs, ID_Rt, ID_Rd  input  5 each  register indices
EX_valid  output  1  EX holds a real instruction
EX_pc  output  pc_size  registered PC
EX_ctrl  output  ctrl_size  registered control
EX_Rs_data, EX_Rt_data, EX_imm  output  data_size  registered operands
EX_Rs, EX_Rt, EX_Rd  output  5 each  registered indices, consumed by the forwarding unit
load_use  output  1  combinational hazard flag
ID_hold  output  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset (rst=0, async): all outputs zero; pending_flush=0.
- load_use = EX_valid & EX_ctrl[1] & (EX_Rd!=0) & ((EX_Rd==ID_Rs) | (EX_Rd==ID_Rt)) & ID_valid.
- ID_hold = load_use & ~stall.
- The register updates at the rising edge. The first matching condition in this priority order wins:
  1. stall=1: hold all EX_* registers. If flush=1, set pending_flush=1.
  2. flush=1 or pending_flush=1: load a bubble and clear pending_flush.
  3. load_use=1: load a bubble. ID is held by ID_hold, so the same instruction re-presents next cycle.
  4. Otherwise: capture all ID_* fields. EX_valid=ID_valid. If ID_valid=0, EX_ctrl=0.
- Bubble: EX_valid=0, EX_ctrl=0, EX_Rs=EX_Rt=EX_Rd=0, data fields=0, EX_pc=0. Rd=0 guarantees the forwarding unit never matches a bubble.
- Latency: one cycle ID->EX. A load-use costs exactly one bubble.
- Flush and load_use in the same cycle: flush wins; one bubble.
- Stall asserted for N cycles: EX_* outputs are unchanged for all N edges. A flush seen during any of them is applied on the first edge with stall=0.
- Stall and load_use in the same cycle: ID_hold=0, because stall already freezes ID; no bubble is inserted.
- Reset mid-operation: pending_flush is cleared; no residual bubble.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds outputs bubble_cnt[31:0] and stall_cnt[31:0], both reset to 0:
  - bubble_cnt increments on each edge that loads a bubble because of load_use.
  - stall_cnt increments on each edge with stall=1.
  - Both counters wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ID_valid=1, ID_Rs_data=0x0000_1234, ID_Rs=5, ID_ctrl=0x01 -> one edge later EX_Rs_data=0x1234, EX_Rs=5, EX_ctrl=0x01, EX_valid=1.
- EX holds a load (EX_ctrl[1]=1, EX_Rd=8) and ID_Rt=8 -> load_use=1, ID_hold=1. Next edge EX_valid=0, EX_ctrl=0, EX_Rd=0. The following edge captures the ID instruction.
- Load in EX with EX_Rd=0 and ID_Rs=0 -> load_use=0; no bubble.
- stall=1 for 3 cycles with ID inputs changing every cycle -> EX_* constant. flush=1 in stall cycle 2 -> the edge after stall drops gives EX_valid=0, EX_ctrl=0.
- flush=1 and load_use=1 together -> exactly one bubble. Next edge captures ID normally (ID_hold was 1, so same instruction).
- Assert rst=0 asynchronously mid-cycle with EX_valid=1 and pending_flush=1 -> all outputs 0 immediately. After release, a normal capture occurs with no bubble. With ID_EX_PERF_CNT_EN defined, two load-use bubbles give bubble_cnt=2.
